// File: rtl/microwave_pkg.sv
// Purpose: shared types and constants for the microwave cook-time controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package microwave_pkg;

    localparam int BCD_W = 4;
    localparam int KEY_W = 10;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t DIGIT_MAX       = 4'd9;
    localparam bcd_t SEC_TENS_RELOAD = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET   = 2'd1,
        COOK  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    // True when exactly one key line is active.
    function automatic logic key_is_onehot(input logic [KEY_W-1:0] k);
        return (k != '0) && ((k & (k - 1'b1)) == '0);
    endfunction

    // Index of the highest active key line; only meaningful when one-hot.
    function automatic bcd_t key_to_digit(input logic [KEY_W-1:0] k);
        bcd_t d;
        d = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (k[i]) begin
                d = BCD_W'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/microwave_ctrl_bcd_timer.sv
// Purpose: three-digit BCD cook time (M:ST) with shift-in, countdown, clear and zero flags.
// Latency: digits update on the clk edge after clr/load/dec is asserted.
// Backpressure: none; one command per cycle, priority clr > load > dec.
module bcd_timer
    import microwave_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  bcd_t digit,
    input  logic dec,
    output bcd_t min_bcd,
    output bcd_t sec_tens_bcd,
    output bcd_t sec_ones_bcd,
    output logic zero,
    output logic one_left
);

    // Digit registers: clear, shift a new digit in from the right, or count down one second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_bcd      <= '0;
            sec_tens_bcd <= '0;
            sec_ones_bcd <= '0;
        end else if (clr) begin
            min_bcd      <= '0;
            sec_tens_bcd <= '0;
            sec_ones_bcd <= '0;
        end else if (load) begin
            // Old minutes digit falls off the left end.
            min_bcd      <= sec_tens_bcd;
            sec_tens_bcd <= sec_ones_bcd;
            sec_ones_bcd <= digit;
        end else if (dec) begin
            // Tens entered above 5 are counted down as-is; reload to 5 only on a minute borrow.
            if (sec_ones_bcd != '0) begin
                sec_ones_bcd <= sec_ones_bcd - 1'b1;
            end else if (sec_tens_bcd != '0) begin
                sec_tens_bcd <= sec_tens_bcd - 1'b1;
                sec_ones_bcd <= DIGIT_MAX;
            end else begin
                min_bcd      <= min_bcd - 1'b1;
                sec_tens_bcd <= SEC_TENS_RELOAD;
                sec_ones_bcd <= DIGIT_MAX;
            end
        end
    end

    // Status flags used by the controller to gate start and detect the final second.
    always_comb begin
        zero     = (min_bcd == '0) && (sec_tens_bcd == '0) && (sec_ones_bcd == '0);
        one_left = (min_bcd == '0) && (sec_tens_bcd == '0) && (sec_ones_bcd == 4'd1);
    end

endmodule

// File: rtl/microwave_ctrl.sv
// Purpose: microwave cook-time controller: keypad entry, start/stop/pause, door interlock, 1 s countdown.
// Latency: button/key edges act on the clk edge after the input changes; mag and digits are registered.
// Backpressure: none; inputs are sampled every cycle, same-cycle conflicts resolved by fixed priority.
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [KEY_W-1:0] keypad,
    input  logic             startn,
    input  logic             stopn,
    input  logic             door_closed,
    output logic             mag,
    output bcd_t             min_bcd,
    output bcd_t             sec_tens_bcd,
    output bcd_t             sec_ones_bcd,
    output logic             done
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_SEC - 1);

    state_t            state;
    state_t            next_state;
    logic              startn_q;
    logic              stopn_q;
    logic              key_q;
    logic [CNT_W-1:0]  tick_cnt;

    logic              any_key;
    logic              key_ev;
    logic              start_ev;
    logic              stop_ev;
    logic              tick;
    bcd_t              key_digit;
    logic              shift_nonzero;

    logic              t_clr;
    logic              t_load;
    logic              t_dec;
    logic              t_zero;
    logic              t_one_left;
    logic              cnt_run;
    logic              done_nxt;

    bcd_timer u_timer (
        .clk          (clk),
        .rst          (clear),
        .clr          (t_clr),
        .load         (t_load),
        .digit        (key_digit),
        .dec          (t_dec),
        .min_bcd      (min_bcd),
        .sec_tens_bcd (sec_tens_bcd),
        .sec_ones_bcd (sec_ones_bcd),
        .zero         (t_zero),
        .one_left     (t_one_left)
    );

    // Edge detection against last cycle's inputs; multi-hot presses are ignored but still arm key_q.
    always_comb begin
        any_key       = |keypad;
        key_ev        = any_key && !key_q && key_is_onehot(keypad);
        start_ev      = startn_q && !startn;
        stop_ev       = stopn_q && !stopn;
        tick          = (tick_cnt == TICK_LAST);
        key_digit     = key_to_digit(keypad);
        // Time after a shift is nonzero iff the two surviving digits or the new one are nonzero.
        shift_nonzero = (sec_tens_bcd != '0) || (sec_ones_bcd != '0) || (key_digit != '0);
    end

    // State, registered outputs, input history and the per-second tick counter.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            startn_q <= 1'b1;
            stopn_q  <= 1'b1;
            key_q    <= 1'b0;
            tick_cnt <= '0;
            mag      <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= next_state;
            startn_q <= startn;
            stopn_q  <= stopn;
            key_q    <= any_key;
            // Counter only runs while staying in COOK, so every (re)entry starts a full second.
            if (cnt_run) begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            end else begin
                tick_cnt <= '0;
            end
            mag      <= (next_state == COOK);
            done     <= done_nxt;
        end
    end

    // Next-state and timer commands; priority door open > stop > start > tick > key.
    always_comb begin
        next_state = state;
        t_clr      = 1'b0;
        t_load     = 1'b0;
        t_dec      = 1'b0;
        cnt_run    = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (key_ev) begin
                    t_load = 1'b1;
                    if (shift_nonzero) begin
                        next_state = SET;
                    end
                end
            end
            SET, PAUSE: begin
                if (stop_ev) begin
                    t_clr      = 1'b1;
                    next_state = IDLE;
                end else if (start_ev && door_closed && !t_zero) begin
                    // Same-cycle key is dropped when start is taken.
                    next_state = COOK;
                end else if (key_ev) begin
                    t_load = 1'b1;
                    // Shifting zeros into SET can empty the time; fall back to IDLE then.
                    if (!shift_nonzero && (state == SET)) begin
                        next_state = IDLE;
                    end
                end
            end
            COOK: begin
                if (!door_closed) begin
                    next_state = PAUSE;
                end else if (stop_ev) begin
                    next_state = PAUSE;
                end else begin
                    cnt_run = 1'b1;
                    if (tick) begin
                        t_dec = 1'b1;
                        if (t_one_left) begin
                            next_state = IDLE;
                            done_nxt   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_microwave_ctrl.sv
module tb_microwave_ctrl;

    logic       clk;
    logic       clear;
    logic [9:0] keypad;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic       mag;
    logic [3:0] min_bcd;
    logic [3:0] sec_tens_bcd;
    logic [3:0] sec_ones_bcd;
    logic       done;

    int checks = 0;
    int errors = 0;

    microwave_ctrl #(.TICKS_PER_SEC(4)) dut (
        .clk          (clk),
        .clear        (clear),
        .keypad       (keypad),
        .startn       (startn),
        .stopn        (stopn),
        .door_closed  (door_closed),
        .mag          (mag),
        .min_bcd      (min_bcd),
        .sec_tens_bcd (sec_tens_bcd),
        .sec_ones_bcd (sec_ones_bcd),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] keypad;
        logic       startn;
        logic       stopn;
        logic       door;
        logic       mag;
        logic [3:0] mi;
        logic [3:0] te;
        logic [3:0] on;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    localparam logic [9:0] NK = 10'd0;
    localparam logic [9:0] MULTI = 10'b1000100000;

    function automatic logic [9:0] kd(input int n);
        logic [9:0] r;
        r = '0;
        r[n] = 1'b1;
        return r;
    endfunction

    task automatic v(input logic [9:0] k, input logic sn, input logic pn, input logic d,
                     input logic m, input int mi, input int te, input int on, input logic dn);
        vec_t x;
        x.keypad = k;
        x.startn = sn;
        x.stopn  = pn;
        x.door   = d;
        x.mag    = m;
        x.mi     = 4'(mi);
        x.te     = 4'(te);
        x.on     = 4'(on);
        x.done   = dn;
        vecs.push_back(x);
    endtask

    // Idle inputs, expected outputs repeated n times.
    task automatic hold(input int n, input logic m, input int mi, input int te, input int on);
        for (int i = 0; i < n; i++) v(NK, 1, 1, 1, m, mi, te, on, 0);
    endtask

    task automatic drive(input logic [9:0] k, input logic sn, input logic pn, input logic d);
        keypad      = k;
        startn      = sn;
        stopn       = pn;
        door_closed = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Entry 1,9,9 with a multi-hot press in between, then stop in SET.
        v(kd(1), 1, 1, 1, 0, 0, 0, 1, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 1, 0);
        v(kd(9), 1, 1, 1, 0, 0, 1, 9, 0);
        v(NK,    1, 1, 1, 0, 0, 1, 9, 0);
        v(kd(9), 1, 1, 1, 0, 1, 9, 9, 0);
        v(NK,    1, 1, 1, 0, 1, 9, 9, 0);
        v(MULTI, 1, 1, 1, 0, 1, 9, 9, 0);
        v(NK,    1, 1, 1, 0, 1, 9, 9, 0);
        v(NK,    1, 0, 1, 0, 0, 0, 0, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 0, 0);
        // Cook run 0:03 to done.
        v(kd(0), 1, 1, 1, 0, 0, 0, 0, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 0, 0);
        v(kd(0), 1, 1, 1, 0, 0, 0, 0, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 0, 0);
        v(kd(3), 1, 1, 1, 0, 0, 0, 3, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 3, 0);
        v(NK,    0, 1, 1, 1, 0, 0, 3, 0);
        hold(3, 1, 0, 0, 3);
        hold(4, 1, 0, 0, 2);
        hold(4, 1, 0, 0, 1);
        v(NK,    1, 1, 1, 0, 0, 0, 0, 1);
        v(NK,    1, 1, 1, 0, 0, 0, 0, 0);
        // Borrow 1:00 -> 0:59 -> 0:58, then stop twice.
        v(kd(1), 1, 1, 1, 0, 0, 0, 1, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 1, 0);
        v(kd(0), 1, 1, 1, 0, 0, 1, 0, 0);
        v(NK,    1, 1, 1, 0, 0, 1, 0, 0);
        v(kd(0), 1, 1, 1, 0, 1, 0, 0, 0);
        v(NK,    1, 1, 1, 0, 1, 0, 0, 0);
        v(NK,    0, 1, 1, 1, 1, 0, 0, 0);
        hold(3, 1, 1, 0, 0);
        hold(4, 1, 0, 5, 9);
        v(NK,    1, 1, 1, 1, 0, 5, 8, 0);
        v(NK,    1, 0, 1, 0, 0, 5, 8, 0);
        v(NK,    1, 1, 1, 0, 0, 5, 8, 0);
        v(NK,    1, 0, 1, 0, 0, 0, 0, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 0, 0);
        // Door interlock at 0:05, start with door open ignored, resume.
        v(kd(5), 1, 1, 1, 0, 0, 0, 5, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 5, 0);
        v(NK,    0, 1, 1, 1, 0, 0, 5, 0);
        v(NK,    1, 1, 1, 1, 0, 0, 5, 0);
        v(NK,    1, 1, 0, 0, 0, 0, 5, 0);
        v(NK,    0, 1, 0, 0, 0, 0, 5, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 5, 0);
        v(NK,    0, 1, 1, 1, 0, 0, 5, 0);
        hold(3, 1, 0, 0, 5);
        hold(4, 1, 0, 0, 4);
        // Door opens on the tick cycle: pause and the tick is lost.
        v(NK,    1, 1, 0, 0, 0, 0, 4, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 4, 0);
        v(NK,    1, 0, 1, 0, 0, 0, 0, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 0, 0);
        // Start and stop together in SET: stop wins.
        v(kd(7), 1, 1, 1, 0, 0, 0, 7, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 7, 0);
        v(NK,    0, 0, 1, 0, 0, 0, 0, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 0, 0);
        // Start and key together: key dropped; key during COOK ignored.
        v(kd(2), 1, 1, 1, 0, 0, 0, 2, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 2, 0);
        v(kd(4), 0, 1, 1, 1, 0, 0, 2, 0);
        v(NK,    1, 1, 1, 1, 0, 0, 2, 0);
        v(kd(8), 1, 1, 1, 1, 0, 0, 2, 0);
        v(NK,    1, 1, 1, 1, 0, 0, 2, 0);
        v(NK,    1, 1, 1, 1, 0, 0, 1, 0);
        v(NK,    1, 0, 1, 0, 0, 0, 1, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 1, 0);
        v(NK,    1, 0, 1, 0, 0, 0, 0, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 0, 0);
        // Start with zero time ignored.
        v(NK,    0, 1, 1, 0, 0, 0, 0, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 0, 0);
        // Tens above 5 counted as-is: 1:60 -> 1:59.
        v(kd(1), 1, 1, 1, 0, 0, 0, 1, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 1, 0);
        v(kd(6), 1, 1, 1, 0, 0, 1, 6, 0);
        v(NK,    1, 1, 1, 0, 0, 1, 6, 0);
        v(kd(0), 1, 1, 1, 0, 1, 6, 0, 0);
        v(NK,    1, 1, 1, 0, 1, 6, 0, 0);
        v(NK,    0, 1, 1, 1, 1, 6, 0, 0);
        hold(3, 1, 1, 6, 0);
        v(NK,    1, 1, 1, 1, 1, 5, 9, 0);
        v(NK,    1, 0, 1, 0, 1, 5, 9, 0);
        v(NK,    1, 1, 1, 0, 1, 5, 9, 0);
        v(NK,    1, 0, 1, 0, 0, 0, 0, 0);
        v(NK,    1, 1, 1, 0, 0, 0, 0, 0);

        // Reset state.
        clear       = 1'b1;
        keypad      = NK;
        startn      = 1'b1;
        stopn       = 1'b1;
        door_closed = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mag", {15'd0, mag}, 16'd0);
        chk("reset_digits", {4'd0, min_bcd, sec_tens_bcd, sec_ones_bcd}, 16'h0000);
        chk("reset_done", {15'd0, done}, 16'd0);
        clear = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].keypad, vecs[i].startn, vecs[i].stopn, vecs[i].door);
            checks++;
            if (mag !== vecs[i].mag || min_bcd !== vecs[i].mi || sec_tens_bcd !== vecs[i].te ||
                sec_ones_bcd !== vecs[i].on || done !== vecs[i].done) begin
                errors++;
                $display("FAIL vec%0d: got mag=%b %h:%h%h done=%b expected mag=%b %h:%h%h done=%b",
                         i, mag, min_bcd, sec_tens_bcd, sec_ones_bcd, done,
                         vecs[i].mag, vecs[i].mi, vecs[i].te, vecs[i].on, vecs[i].done);
            end
        end

        // Asynchronous clear in the middle of a cook run.
        drive(kd(8), 1, 1, 1);
        drive(NK, 1, 1, 1);
        drive(NK, 0, 1, 1);
        drive(NK, 1, 1, 1);
        chk("precook_mag", {15'd0, mag}, 16'd1);
        chk("precook_digits", {4'd0, min_bcd, sec_tens_bcd, sec_ones_bcd}, 16'h0008);
        clear = 1'b1;
        #2;
        chk("async_clear_mag", {15'd0, mag}, 16'd0);
        chk("async_clear_digits", {4'd0, min_bcd, sec_tens_bcd, sec_ones_bcd}, 16'h0000);
        @(posedge clk);
        #1;
        clear = 1'b0;
        drive(NK, 1, 1, 1);
        chk("after_clear_mag", {15'd0, mag}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl.md
# microwave_ctrl

Cook-time controller for the microwave: captures keypad digits into a three-digit BCD time (M:ST), sequences start/stop/pause with the door interlock, counts the time down once per second, and drives the magnetron enable. It sits between the keypad/button inputs and the magnetron, and feeds BCD digits to the seven-segment encoders.

## Interface
- TICKS_PER_SEC, default 50: clk cycles per one-second countdown step (50 matches the 20 ms system clock).
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset and global clear.
- keypad  in  10  one-hot digit keys; bit i = digit i.
- startn  in  1  start button, active low.
- stopn  in  1  stop button, active low.
- door_closed  in  1  1 = door closed.
- mag  out  1  magnetron enable, registered.
- min_bcd  out  4  minutes digit.
- sec_tens_bcd  out  4  seconds tens digit.
- sec_ones_bcd  out  4  seconds ones digit.
- done  out  1  one-cycle pulse when a cook run reaches 0:00.

## Operation
- States: IDLE (time 0:00), SET (nonzero time, not cooking), COOK, PAUSE.
- Reset (clear=1, async): state IDLE; all digits 0; mag 0; done 0; tick counter 0; edge-detect registers 1 for startn/stopn, 0 for key.
- Key accept: rising edge of "any key" where keypad is exactly one-hot. Multi-hot or zero is ignored. Accepted only in IDLE, SET and PAUSE. Shift: min <= sec_tens, sec_tens <= sec_ones, sec_ones <= digit; old min is discarded. If the result is nonzero from IDLE, go to SET.
- Start: falling edge of startn. Taken in SET or PAUSE only when door_closed=1 and the time is nonzero; otherwise ignored. Moves to COOK and clears the tick counter.
- Stop: falling edge of stopn.
  - In COOK: go to PAUSE and keep the time.
  - In SET or PAUSE: zero all digits and go to IDLE.
  - In IDLE: no effect.
- Door: door_closed=0 in COOK moves to PAUSE.
- Countdown in COOK: the tick counter runs 0..TICKS_PER_SEC-1. On wrap, decrement the BCD time:
  - if ones > 0: ones-1;
  - else if tens > 0: tens-1 and ones=9;
  - else: min-1, tens=5, ones=9.
  - Entered tens above 5 are counted as-is, so 1:99 runs 1:98 … 1:00, then 0:59.
- Reaching 0:00 by decrement: go to IDLE and pulse done for one cycle.
- mag = 1 exactly while in COOK.
- Priority within one cycle: clear > door open > stop > start > tick > key.
  - Stop and start together: stop wins.
  - Door open and tick together: pause, and the tick is discarded.
  - Start and key together in SET/PAUSE: start is taken and the key is dropped.

## Timing
- Button and key edges are detected against a registered copy, so an action takes effect on the clk edge after the input changes (1-cycle latency).
- mag rises on the edge that enters COOK and falls on the edge that leaves COOK.
- First decrement happens TICKS_PER_SEC cycles after entering COOK.
- Tick count is not retained across PAUSE; resume restarts a full second.
- Digit outputs are registered and change on the same edge as the state update.
- done is high for exactly the cycle after the final decrement, coincident with state IDLE and mag 0.
- Inputs are assumed synchronous to clk; debouncing is upstream.

## Structure
- Package microwave_pkg holds:
  - state enum (IDLE, SET, COOK, PAUSE);
  - BCD digit width 4;
  - constants for digit max 9 and seconds-tens reload 5;
  - keypad width 10.
- One sub-module, bcd_timer, holds the three BCD digit registers with shift-in (load digit), decrement, clear and zero-flag. microwave_ctrl holds the FSM, edge detectors and tick counter.

## Test plan
Benches use TICKS_PER_SEC=4.
- Reset/entry: pulse clear, then enter keys 1, 9, 9 → digits 1:99, state SET, mag 0.
- Cook run: enter 0, 0, 3, then drop startn → mag=1 next edge; time reads 0:02, 0:01, 0:00 at 4-cycle intervals; done pulses once; mag=0 and IDLE afterward.
- Borrow: enter 1, 0, 0 and start → after 4 cycles 0:59, and 0:58 after 4 more.
- Door interlock: during COOK at 0:05, drop door_closed → PAUSE, mag=0, time holds 0:05. Start with the door open is ignored. Close the door and start → COOK resumes and reaches 0:04 after 4 cycles.
- Stop semantics: stop in COOK → PAUSE with the time kept; a second stop → IDLE with 0:00. Multi-hot keypad 10'b1000100000 → time unchanged.
- Simultaneous and async events: startn and stopn fall in the same cycle in SET → IDLE. Assert clear mid-COOK → mag=0 and all digits 0 immediately, without waiting for a clk edge.
